power_vector_driver: RTL and testbench

//   Sequential stimulus/response harness for the 4-input power sub-circuits.

---
 rtl/power_vector_driver.sv | 218 +++++++++++++++++++++
 tb/tb_power_vector_driver.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/power_vector_driver.sv
// power_vector_driver
//   Stimulus/response harness for small combinational power sub-circuits.
//   On an accepted start it loads a 16-bit Fibonacci LFSR from the seed. It then
//   drives num_vec pseudo-random vectors, one per cycle, into the DUT. It
//   samples the DUT's single output for each vector and accumulates
//   switching-activity counts.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   start_i        begin a run (accepted only in IDLE or DONE)
//   num_vec_i      number of vectors to apply, captured on accepted start
//   seed_i         LFSR seed, captured on accepted start (0 is replaced by 1)
//   vec_out_o      registered vector driven to the DUT inputs
//   vec_valid_o    vec_out_o holds a live vector this cycle
//   dut_out_i      DUT output, a combinational function of vec_out_o
//   busy_o         high while loading or running
//   done_o         high after a run until the next accepted start
//   in_toggles_o   total input bit flips between consecutive vectors
//   out_toggles_o  number of DUT output changes between consecutive samples
//   out_ones_o     number of samples where the DUT output was 1
module power_vector_driver #(
  parameter int N_IN  = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] num_vec_i,
  input  logic [15:0]      seed_i,
  output logic [N_IN-1:0]  vec_out_o,
  output logic             vec_valid_o,
  input  logic             dut_out_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] in_toggles_o,
  output logic [CNT_W-1:0] out_toggles_o,
  output logic [CNT_W-1:0] out_ones_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // x^16+x^14+x^13+x^11+1, shifting towards the MSB
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    lfsr_next = {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
  endfunction

  // Number of set bits; 5 bits covers the widest supported vector (16)
  function automatic logic [4:0] popcount(input logic [N_IN-1:0] v);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < N_IN; i++) begin
      cnt = cnt + {4'b0000, v[i]};
    end
    popcount = cnt;
  endfunction

  // Add a small increment and clamp at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [4:0]       b);
    logic [CNT_W+4:0] s;
    s = {5'b00000, a} + {{CNT_W{1'b0}}, b};
    if (s > {5'b00000, CNT_MAX}) begin
      sat_add = CNT_MAX;
    end else begin
      sat_add = s[CNT_W-1:0];
    end
  endfunction

  state_t           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] in_tog_q, in_tog_d;
  logic [CNT_W-1:0] out_tog_q, out_tog_d;
  logic [CNT_W-1:0] out_ones_q, out_ones_d;
  logic             prev_q, prev_d;
  // Set until the first sample of a run; that sample has no predecessor to compare with
  logic             first_q, first_d;

  // Next-state and datapath decisions for the whole run sequence
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    num_d      = num_q;
    issued_d   = issued_q;
    vec_d      = vec_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    done_d     = done_q;
    in_tog_d   = in_tog_q;
    out_tog_d  = out_tog_q;
    out_ones_d = out_ones_q;
    prev_d     = prev_q;
    first_d    = first_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d    = ST_LOAD;
          num_d      = num_vec_i;
          // An all-zero LFSR would lock up, so a zero seed is promoted to 1
          lfsr_d     = (seed_i == 16'h0000) ? 16'h0001 : seed_i;
          in_tog_d   = CNT_ZERO;
          out_tog_d  = CNT_ZERO;
          out_ones_d = CNT_ZERO;
          busy_d     = 1'b1;
          done_d     = 1'b0;
        end else begin
          state_d = state_q;
        end
      end

      ST_LOAD: begin
        if (num_q == CNT_ZERO) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          // First vector: nothing before it, so no input toggle is counted
          state_d  = ST_RUN;
          vec_d    = lfsr_q[N_IN-1:0];
          valid_d  = 1'b1;
          lfsr_d   = lfsr_next(lfsr_q);
          issued_d = CNT_ONE;
          first_d  = 1'b1;
        end
      end

      ST_RUN: begin
        // The sample taken now belongs to the vector currently on vec_out
        out_ones_d = sat_add(out_ones_q, {4'b0000, dut_out_i});
        if (first_q) begin
          out_tog_d = out_tog_q;
        end else begin
          out_tog_d = sat_add(out_tog_q, {4'b0000, dut_out_i ^ prev_q});
        end
        prev_d  = dut_out_i;
        first_d = 1'b0;

        if (issued_q < num_q) begin
          vec_d    = lfsr_q[N_IN-1:0];
          in_tog_d = sat_add(in_tog_q, popcount(lfsr_q[N_IN-1:0] ^ vec_q));
          lfsr_d   = lfsr_next(lfsr_q);
          issued_d = issued_q + CNT_ONE;
        end else begin
          // Last vector has been sampled; vec_out keeps its final value
          state_d = ST_DONE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      lfsr_q     <= 16'h0001;
      num_q      <= CNT_ZERO;
      issued_q   <= CNT_ZERO;
      vec_q      <= {N_IN{1'b0}};
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      in_tog_q   <= CNT_ZERO;
      out_tog_q  <= CNT_ZERO;
      out_ones_q <= CNT_ZERO;
      prev_q     <= 1'b0;
      first_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      num_q      <= num_d;
      issued_q   <= issued_d;
      vec_q      <= vec_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      in_tog_q   <= in_tog_d;
      out_tog_q  <= out_tog_d;
      out_ones_q <= out_ones_d;
      prev_q     <= prev_d;
      first_q    <= first_d;
    end
  end

  assign vec_out_o     = vec_q;
  assign vec_valid_o   = valid_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign in_toggles_o  = in_tog_q;
  assign out_toggles_o = out_tog_q;
  assign out_ones_o    = out_ones_q;

endmodule

// File: tb/tb_power_vector_driver.sv
// Scoreboard bench for power_vector_driver: expected vectors and counts come
// from a reference LFSR model; the vectors are queued when a run is launched
// and popped as the DUT presents them. A second instance with 4-bit counters
// exercises saturation.
module tb_power_vector_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_vec;
  logic [15:0] seed;
  logic        dut_out;
  logic        dut4_out;
  int          mode;

  logic [3:0]  vec_out;
  logic        vec_valid, busy, done;
  logic [15:0] in_toggles, out_toggles, out_ones;

  logic [3:0]  vec_out4;
  logic        vec_valid4, busy4, done4;
  logic [3:0]  in_toggles4, out_toggles4, out_ones4;

  int          checks = 0;
  int          errors = 0;
  logic [3:0]  exp_q[$];

  always #5 clk = ~clk;

  // mode 0: DUT output 0, 1: output 1, 2: output follows vec_out[0]
  assign dut_out = (mode == 2) ? vec_out[0] : (mode == 1);

  power_vector_driver #(.N_IN(4), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .num_vec_i(num_vec), .seed_i(seed),
    .vec_out_o(vec_out), .vec_valid_o(vec_valid), .dut_out_i(dut_out),
    .busy_o(busy), .done_o(done), .in_toggles_o(in_toggles),
    .out_toggles_o(out_toggles), .out_ones_o(out_ones)
  );

  power_vector_driver #(.N_IN(4), .CNT_W(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .num_vec_i(num_vec[3:0]), .seed_i(seed),
    .vec_out_o(vec_out4), .vec_valid_o(vec_valid4), .dut_out_i(dut4_out),
    .busy_o(busy4), .done_o(done4), .in_toggles_o(in_toggles4),
    .out_toggles_o(out_toggles4), .out_ones_o(out_ones4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference run: expected vectors (optionally queued) and saturated counts
  task automatic model(input logic [15:0] sd, input int n, input int md, input int mx,
                       input bit push, output int e_in, output int e_ot, output int e_on);
    logic [15:0] lf;
    logic [3:0]  v, pv;
    logic        d, pd;
    e_in = 0; e_ot = 0; e_on = 0;
    pv = 4'h0; pd = 1'b0;
    lf = (sd == 16'h0000) ? 16'h0001 : sd;
    for (int i = 0; i < n; i++) begin
      v = lf[3:0];
      if (push) exp_q.push_back(v);
      if (i > 0) e_in += $countones(v ^ pv);
      case (md)
        0:       d = 1'b0;
        1:       d = 1'b1;
        2:       d = v[0];
        default: d = i[0];
      endcase
      if (d) e_on++;
      if (i > 0 && d != pd) e_ot++;
      pv = v;
      pd = d;
      lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
    end
    if (e_in > mx) e_in = mx;
    if (e_ot > mx) e_ot = mx;
    if (e_on > mx) e_on = mx;
  endtask

  // Vector scoreboard: every live vector must match the head of the queue
  always @(negedge clk) begin
    logic [3:0] ev;
    if (vec_valid) begin
      if (exp_q.size() == 0) begin
        chk("vec_unexpected", {28'd0, vec_out}, 32'hFFFF_FFFF);
      end else begin
        ev = exp_q.pop_front();
        chk("vec", {28'd0, vec_out}, {28'd0, ev});
      end
    end
  end

  // Launch one run, watch its timing, then compare the final counts
  task automatic do_run(input string tag, input logic [15:0] sd, input int n,
                        input int md, input bit poke);
    int e_in, e_ot, e_on, lat, vseen, bseen;
    bit got_done;
    model(sd, n, md, 65535, 1'b1, e_in, e_ot, e_on);
    mode = md;
    @(negedge clk);
    seed = sd;
    num_vec = n[15:0];
    start = 1'b1;
    lat = 0; vseen = 0; bseen = 0; got_done = 1'b0;
    for (int k = 1; k <= n + 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke && k == 3) begin
        // must be ignored while busy
        start = 1'b1;
        num_vec = 16'd3;
        seed = 16'h5555;
      end
      if (vec_valid) begin
        dut4_out = vseen[0];
        vseen++;
      end
      if (busy) bseen++;
      if (done) begin
        lat = k;
        got_done = 1'b1;
        break;
      end
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, {31'd0, got_done}, 32'd1);
    chk({tag, "_done_latency"}, lat, (n == 0) ? 2 : n + 2);
    chk({tag, "_valid_cycles"}, vseen, n);
    chk({tag, "_busy_cycles"}, bseen, n + 1);
    chk({tag, "_in_toggles"}, {16'd0, in_toggles}, e_in);
    chk({tag, "_out_toggles"}, {16'd0, out_toggles}, e_ot);
    chk({tag, "_out_ones"}, {16'd0, out_ones}, e_on);
    chk({tag, "_queue_left"}, exp_q.size(), 0);
  endtask

  initial begin
    int e_in, e_ot, e_on, vseen;
    mode = 0;
    dut4_out = 1'b0;
    num_vec = 16'd5;
    seed = 16'h0000;
    // start together with reset: reset must win
    rst = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_valid", {31'd0, vec_valid}, 32'd0);
    chk("rst_vec", {28'd0, vec_out}, 32'd0);
    chk("rst_counts", {in_toggles, out_ones}, 32'd0);
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // 1: zero seed, single vector 4'h1
    do_run("t1", 16'h0000, 1, 0, 1'b0);
    // 2: zero vectors
    do_run("t2", 16'hBEEF, 0, 1, 1'b0);
    // 3: output tied high, ignored start while busy
    do_run("t3", 16'hACE1, 10, 1, 1'b1);
    // 4: output follows vec_out[0]
    do_run("t4", 16'h0001, 20, 2, 1'b0);
    chk("t4_out_toggles_le19", {31'd0, (out_toggles <= 16'd19)}, 32'd1);
    // 5: 4-bit counters, alternating output on the second instance
    do_run("t5", 16'hACE1, 15, 1, 1'b0);
    model(16'hACE1, 15, 3, 15, 1'b0, e_in, e_ot, e_on);
    chk("t5_c4_done", {31'd0, done4}, 32'd1);
    chk("t5_c4_in_toggles", {28'd0, in_toggles4}, e_in);
    chk("t5_c4_in_saturated", {28'd0, in_toggles4}, 32'd15);
    chk("t5_c4_out_toggles", {28'd0, out_toggles4}, 32'd14);
    chk("t5_c4_out_ones", {28'd0, out_ones4}, e_on);

    // 6: reset in the middle of a run
    model(16'h00FF, 10, 1, 65535, 1'b1, e_in, e_ot, e_on);
    mode = 1;
    @(negedge clk);
    seed = 16'h00FF;
    num_vec = 16'd10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vseen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (vec_valid) vseen++;
      if (vseen == 5) break;
    end
    chk("t6_reached_vec5", vseen, 5);
    #2 rst = 1'b1;
    #1;
    chk("t6_busy_async", {31'd0, busy}, 32'd0);
    chk("t6_valid_async", {31'd0, vec_valid}, 32'd0);
    chk("t6_counts_cleared", {in_toggles, out_ones}, 32'd0);
    chk("t6_out_toggles_cleared", {16'd0, out_toggles}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    do_run("t6b", 16'h1234, 7, 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
